axi_lite_cfg_master: RTL and testbench
======================================

AXI_LITE_CFG_MASTER -- requirements
Module: axi_lite_cfg_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: handshake-wait limit per transaction, range 2..65535.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 cmd_write  input  1  1 = register write, 0 = register read.
REQ-007 cmd_addr  input  32  target byte address.
REQ-008 cmd_wdata  input  32  write data; ignored for reads.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  transaction aborted by timeout.
REQ-013 m_awvalid/m_awaddr[31:0]/m_awready  out/out/in  AXI-Lite write address channel.
REQ-014 m_wvalid/m_wdata[31:0]/m_wready  out/out/in  AXI-Lite write data channel.
REQ-015 m_bvalid/m_bready  in/out  AXI-Lite write response channel; no BRESP.
REQ-016 m_arvalid/m_araddr[31:0]/m_arready  out/out/in  AXI-Lite read address channel.
REQ-017 m_rvalid/m_rdata[31:0]/m_rready  in/in/out  AXI-Lite read data channel; no RRESP.

Function
REQ-018 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RESP.
REQ-019 cmd_ready SHALL be high only in IDLE; at most one transaction outstanding.
REQ-020 On cmd acceptance, address and data SHALL be captured; next state WR_REQ if cmd_write, else RD_REQ.
REQ-021 All m_* and rsp_* outputs SHALL be registered; m_awvalid and m_wvalid rise together one cycle after acceptance.
REQ-022 WR_REQ: m_awvalid and m_wvalid SHALL each drop in the cycle after their own handshake, independently; AW and W handshakes in either order or in the same cycle are legal.
REQ-023 WR_REQ -> WR_RESP once both AW and W have completed; m_bready SHALL be high throughout WR_RESP.
REQ-024 WR_RESP -> RESP on m_bvalid; rsp_rdata=0, rsp_err=0.
REQ-025 RD_REQ: m_arvalid high until m_arready; then RD_DATA with m_rready high.
REQ-026 RD_DATA -> RESP on m_rvalid; rsp_rdata SHALL capture m_rdata in that cycle; rsp_err=0.
REQ-027 RESP: rsp_valid SHALL hold, with rsp_rdata and rsp_err stable, until rsp_ready; then IDLE; cmd_ready rises the following cycle.
REQ-028 Valid/ready outputs SHALL never depend combinationally on the corresponding ready/valid input.
REQ-029 A 16-bit wait counter SHALL clear on cmd acceptance and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-030 When the counter reaches TIMEOUT_CYCLES-1 without completion: all m_*valid and m_*ready SHALL drop on the next edge; state -> RESP with rsp_err=1 and rsp_rdata=0.
REQ-031 If completion and timeout coincide in the same cycle, completion SHALL win (rsp_err=0).
REQ-032 m_bvalid and m_rvalid arriving outside WR_RESP and RD_DATA respectively SHALL be ignored.
REQ-033 m_awaddr, m_araddr and m_wdata SHALL remain stable while their valid is high.

Reset
REQ-034 On rstn low, asynchronously: state IDLE, all m_*valid, m_bready, m_rready, rsp_valid and rsp_err = 0, all addr/data outputs = 0, counter = 0.
REQ-035 cmd_ready SHALL be 1 from the first rising edge after rstn deasserts.
REQ-036 Reset mid-transaction SHALL abort it with no response emitted.

Verification
REQ-037 Write addr 0x0000_0000 data 0x0000_1000 with AW/W/B ready at zero wait -> one AW and one W handshake; rsp_valid with rsp_err=0 and rsp_rdata=0.
REQ-038 m_wready 3 cycles before m_awready, then m_bvalid delayed 2 cycles -> each valid drops independently after its handshake; single response with rsp_err=0.
REQ-039 Read addr 0x0000_0008 with responder returning 0x0000_0040 after 4 cycles -> rsp_rdata=0x0000_0040, rsp_err=0; rsp_valid held 3 cycles under rsp_ready low.
REQ-040 TIMEOUT_CYCLES=8, m_arready tied 0 -> m_arvalid drops after 8 wait cycles; rsp_err=1, rsp_rdata=0; next command accepted normally.
REQ-041 rstn pulsed low during WR_RESP -> all outputs 0 immediately and no rsp_valid; cmd_ready=1 after release; next read completes correctly.
REQ-042 Back-to-back write 0x0C<-0x1 then read 0x0C with rsp_ready tied 1 -> exactly two responses in order; no overlap of channel valids.

Source files
------------

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master: turns single register read/write commands into
// AXI-Lite transactions, one at a time, with a per-transaction wait limit.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | driving AW and W until both have handshaken
// WR_RESP | m_bready high, waiting for m_bvalid
// RD_REQ  | driving AR until m_arready
// RD_DATA | m_rready high, waiting for m_rvalid
// RESP    | holding rsp_* until rsp_ready
module axi_lite_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_awvalid,
  output logic [31:0] m_awaddr,
  input  logic        m_awready,
  output logic        m_wvalid,
  output logic [31:0] m_wdata,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        m_arvalid,
  output logic [31:0] m_araddr,
  input  logic        m_arready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        m_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

  // Last wait-count value tolerated before the transaction is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        cmd_fire;
  logic        aw_fire;
  logic        w_fire;
  logic        aw_done;
  logic        w_done;
  logic        timeout;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign aw_fire  = m_awvalid & m_awready;
  assign w_fire   = m_wvalid & m_wready;
  // A channel whose valid has already dropped finished in an earlier cycle.
  assign aw_done  = aw_fire | ~m_awvalid;
  assign w_done   = w_fire | ~m_wvalid;
  // >= so a late completion that pushed the count past the limit still times out next cycle.
  assign timeout  = (wait_cnt >= WAIT_LAST);

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_wvalid  <= 1'b0;
      m_wdata   <= '0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_rready  <= 1'b0;
    end else begin
      if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            if (cmd_write) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              m_awaddr  <= cmd_addr;
              m_wdata   <= cmd_wdata;
              state     <= WR_REQ;
            end else begin
              m_arvalid <= 1'b1;
              m_araddr  <= cmd_addr;
              state     <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_fire) m_awvalid <= 1'b0;
          if (w_fire)  m_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end else if (timeout) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid || timeout) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~m_bvalid;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end else if (timeout) begin
            m_arvalid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RD_DATA: begin
          if (m_rvalid || timeout) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~m_rvalid;
            rsp_rdata <= m_rvalid ? m_rdata : 32'd0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Directed bench for axi_lite_cfg_master with an 8-cycle wait limit.
module tb_axi_lite_cfg_master;

  logic        clk;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;

  int total = 0;
  int bad = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
  int overlap_cnt = 0;

  axi_lite_cfg_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters and channel-overlap watcher.
  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_cnt++;
    if (m_wvalid && m_wready) w_cnt++;
    if (m_bvalid && m_bready) b_cnt++;
    if (m_arvalid && m_arready) ar_cnt++;
    if (m_rvalid && m_rready) r_cnt++;
    if (rsp_valid && rsp_ready) rsp_cnt++;
    if (((m_awvalid || m_wvalid) && m_arvalid) || (rsp_valid && (m_awvalid || m_wvalid || m_arvalid)))
      overlap_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  // Drives one command against an always-ready responder; rdval is returned on reads.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdval, output logic [31:0] got_rdata,
                         output logic got_err, output logic got);
    logic acc;
    got = 0; got_rdata = '0; got_err = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    m_awready = 1; m_wready = 1; m_arready = 1; rsp_ready = 1;
    for (int n = 0; n < 40 && !got; n++) begin
      m_bvalid = m_bready; m_rvalid = m_rready; m_rdata = rdval;
      if (rsp_valid) begin got_rdata = rsp_rdata; got_err = rsp_err; got = 1; end
      acc = cmd_valid && cmd_ready;
      tick;
      if (acc) cmd_valid = 0;
    end
    idle_inputs;
  endtask

  task automatic test_reset;
    idle_inputs;
    rstn = 0;
    #12;
    total++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err}); end
    total++; if ({m_awaddr, m_wdata, m_araddr, rsp_rdata} !== 128'b0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {m_awaddr, m_wdata, m_araddr, rsp_rdata}); end
    @(posedge clk); #1 rstn = 1;
    tick;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, r0 = rsp_cnt;
    m_awready = 1; m_wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'h0000_1000;
    tick; cmd_valid = 0;
    total++; if ({m_awvalid, m_wvalid, cmd_ready} !== 3'b110) begin
      bad++; $display("FAIL wr0_valids: got %b want 110", {m_awvalid, m_wvalid, cmd_ready}); end
    total++; if (m_wdata !== 32'h0000_1000 || m_awaddr !== 32'h0) begin
      bad++; $display("FAIL wr0_payload: got %h/%h want 00000000/00001000", m_awaddr, m_wdata); end
    tick;
    total++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin
      bad++; $display("FAIL wr0_bready: got %b want 001", {m_awvalid, m_wvalid, m_bready}); end
    m_bvalid = 1; tick; m_bvalid = 0;
    total++; if ({rsp_valid, rsp_err, m_bready} !== 3'b100 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL wr0_rsp: got %b rdata %h want 100 rdata 0", {rsp_valid, rsp_err, m_bready}, rsp_rdata); end
    rsp_ready = 1; tick; idle_inputs;
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL wr0_done: got %b want 01", {rsp_valid, cmd_ready}); end
    total++; if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1 || rsp_cnt - r0 != 1) begin
      bad++; $display("FAIL wr0_hs_count: got aw%0d w%0d b%0d rsp%0d want 1 each", aw_cnt - aw0, w_cnt - w0, b_cnt - b0, rsp_cnt - r0); end
  endtask

  task automatic test_write_skewed;
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, r0 = rsp_cnt;
    m_wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h24; cmd_wdata = 32'hA5A5_0001;
    tick; cmd_valid = 0;
    total++; if ({m_awvalid, m_wvalid} !== 2'b11) begin bad++; $display("FAIL skew_c0: got %b want 11", {m_awvalid, m_wvalid}); end
    tick;
    total++; if ({m_awvalid, m_wvalid} !== 2'b10 || m_awaddr !== 32'h24) begin
      bad++; $display("FAIL skew_w_drop: got %b addr %h want 10 addr 00000024", {m_awvalid, m_wvalid}, m_awaddr); end
    tick; tick;
    m_awready = 1; tick; m_awready = 0;
    total++; if ({m_awvalid, m_wvalid, m_bready, rsp_valid} !== 4'b0010) begin
      bad++; $display("FAIL skew_aw_drop: got %b want 0010", {m_awvalid, m_wvalid, m_bready, rsp_valid}); end
    tick; tick;
    m_bvalid = 1; tick; m_bvalid = 0;
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL skew_rsp: got %b rdata %h want 10 rdata 0", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1; tick; idle_inputs;
    total++; if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1 || rsp_cnt - r0 != 1) begin
      bad++; $display("FAIL skew_hs_count: got aw%0d w%0d b%0d rsp%0d want 1 each", aw_cnt - aw0, w_cnt - w0, b_cnt - b0, rsp_cnt - r0); end
  endtask

  task automatic test_read_hold;
    int held = 0;
    m_arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
    tick; cmd_valid = 0;
    total++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8) begin
      bad++; $display("FAIL rd_ar: got %b addr %h want 1 addr 00000008", m_arvalid, m_araddr); end
    tick; m_arready = 0;
    total++; if ({m_arvalid, m_rready} !== 2'b01) begin bad++; $display("FAIL rd_rready: got %b want 01", {m_arvalid, m_rready}); end
    tick; tick; tick;
    m_rvalid = 1; m_rdata = 32'h0000_0040;
    tick; m_rvalid = 0; m_rdata = 32'hDEAD_BEEF;
    total++; if ({rsp_valid, rsp_err, m_rready} !== 3'b100 || rsp_rdata !== 32'h40) begin
      bad++; $display("FAIL rd_rsp: got %b rdata %h want 100 rdata 00000040", {rsp_valid, rsp_err, m_rready}, rsp_rdata); end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (rsp_valid === 1'b1 && rsp_rdata === 32'h40 && rsp_err === 1'b0) held++;
    end
    total++; if (held != 3) begin bad++; $display("FAIL rd_hold: got %0d cycles want 3", held); end
    rsp_ready = 1; tick; idle_inputs;
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL rd_done: got %b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_timeout;
    int hi = 0;
    int r0 = r_cnt, b0 = b_cnt;
    logic [31:0] rd; logic er, got;
    m_rvalid = 1; m_rdata = 32'h77; m_bvalid = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
    tick; cmd_valid = 0;
    if (m_arvalid === 1'b1) hi++;
    for (int i = 1; i < 8; i++) begin
      tick;
      if (m_arvalid === 1'b1) hi++;
    end
    total++; if (hi != 8) begin bad++; $display("FAIL to_ar_cycles: got %0d want 8", hi); end
    tick;
    total++; if ({m_arvalid, m_rready, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL to_rsp: got %b rdata %h want 0011 rdata 0", {m_arvalid, m_rready, rsp_valid, rsp_err}, rsp_rdata); end
    total++; if (r_cnt != r0 || b_cnt != b0) begin
      bad++; $display("FAIL to_stray: got r%0d b%0d want r%0d b%0d", r_cnt, b_cnt, r0, b0); end
    m_rvalid = 0; m_bvalid = 0;
    rsp_ready = 1; tick; rsp_ready = 0;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL to_cmd_ready: got %b want 1", cmd_ready); end
    run_txn(1'b1, 32'h30, 32'h5, 32'h0, rd, er, got);
    total++; if ({got, er} !== 2'b10 || rd !== 32'h0) begin
      bad++; $display("FAIL to_next_cmd: got done=%b err=%b rdata %h want 1 0 0", got, er, rd); end
  endtask

  task automatic test_timeout_race;
    m_rvalid = 1; m_rdata = 32'h55;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h34;
    tick; cmd_valid = 0;
    for (int i = 1; i < 8; i++) tick;
    m_arready = 1; tick; m_arready = 0;
    total++; if ({m_arvalid, m_rready, rsp_valid} !== 3'b010) begin
      bad++; $display("FAIL race_ar_wins: got %b want 010", {m_arvalid, m_rready, rsp_valid}); end
    tick; m_rvalid = 0;
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h55) begin
      bad++; $display("FAIL race_rsp: got %b rdata %h want 10 rdata 00000055", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1; tick; idle_inputs;
  endtask

  task automatic test_reset_mid;
    int r0;
    logic [31:0] rd; logic er, got;
    m_awready = 1; m_wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h99;
    tick; cmd_valid = 0;
    tick; m_awready = 0; m_wready = 0;
    total++; if (m_bready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_wresp: got %b want 1", m_bready); end
    r0 = rsp_cnt;
    #2 rstn = 0;
    #1;
    total++; if ({cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err} !== 8'b0 ||
                 {m_awaddr, m_wdata, m_araddr, rsp_rdata} !== 128'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b data %h want all 0",
        {cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err}, {m_awaddr, m_wdata, m_araddr, rsp_rdata}); end
    m_bvalid = 1;
    tick; tick;
    rstn = 1;
    tick;
    total++; if ({cmd_ready, rsp_valid, m_bready} !== 3'b100) begin
      bad++; $display("FAIL rst_mid_release: got %b want 100", {cmd_ready, rsp_valid, m_bready}); end
    tick; m_bvalid = 0;
    total++; if (rsp_valid !== 1'b0 || rsp_cnt != r0) begin
      bad++; $display("FAIL rst_mid_no_rsp: got valid %b count %0d want 0 count %0d", rsp_valid, rsp_cnt, r0); end
    run_txn(1'b0, 32'h44, 32'h0, 32'h1234_5678, rd, er, got);
    total++; if ({got, er} !== 2'b10 || rd !== 32'h1234_5678) begin
      bad++; $display("FAIL rst_mid_next_read: got done=%b err=%b rdata %h want 1 0 12345678", got, er, rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] shadow, rd1, rd2;
    logic er1, er2, g1, g2;
    int r0 = rsp_cnt;
    shadow = 32'h1;
    run_txn(1'b1, 32'h0C, shadow, 32'h0, rd1, er1, g1);
    run_txn(1'b0, 32'h0C, 32'h0, shadow, rd2, er2, g2);
    total++; if ({g1, er1} !== 2'b10 || rd1 !== 32'h0) begin
      bad++; $display("FAIL b2b_write: got done=%b err=%b rdata %h want 1 0 0", g1, er1, rd1); end
    total++; if ({g2, er2} !== 2'b10 || rd2 !== 32'h1) begin
      bad++; $display("FAIL b2b_read: got done=%b err=%b rdata %h want 1 0 00000001", g2, er2, rd2); end
    total++; if (rsp_cnt - r0 != 2) begin bad++; $display("FAIL b2b_rsp_count: got %0d want 2", rsp_cnt - r0); end
    total++; if (overlap_cnt != 0) begin bad++; $display("FAIL channel_overlap: got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset;
    test_write_zero_wait;
    test_write_skewed;
    test_read_hold;
    test_timeout;
    test_timeout_race;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
